// File: rtl/sram_bus_arbiter_pkg.sv
// Shared types for the instruction/data SRAM bus arbiter.
package sram_bus_arbiter_pkg;

  // Requester identity carried through the outstanding-transaction FIFO
  typedef enum logic {
    REQ_INST = 1'b0,
    REQ_DATA = 1'b1
  } req_id_e;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sram_bus_arbiter_id_fifo.sv
// In-order FIFO of requester IDs for accepted-but-unreturned transactions.
module sram_bus_arbiter_id_fifo
  import sram_bus_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic head,
  output logic full,
  output logic empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = cnt_width(DEPTH);

  logic [DEPTH-1:0] slots_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!resetn) begin
      slots_r  <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) begin
        slots_r[wr_ptr_r] <= din;
        wr_ptr_r          <= bump(wr_ptr_r);
      end
      if (pop) begin
        rd_ptr_r <= bump(rd_ptr_r);
      end
      // Simultaneous push and pop leaves occupancy unchanged
      if (push && !pop) begin
        count_r <= count_r + CNT_W'(1);
      end else if (pop && !push) begin
        count_r <= count_r - CNT_W'(1);
      end else begin
        count_r <= count_r;
      end
    end
  end

  assign head  = slots_r[rd_ptr_r];
  assign full  = (count_r == CNT_W'(DEPTH));
  assign empty = (count_r == '0);

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one sram-like port between instruction-fetch and data requesters,
// routing in-order responses back to whichever requester issued them.
module sram_bus_arbiter
  import sram_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MAX_OUT = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                inst_req,
  input  logic                inst_wr,
  input  logic [1:0]          inst_size,
  input  logic [DATA_W/8-1:0] inst_wstrb,
  input  logic [ADDR_W-1:0]   inst_addr,
  input  logic [DATA_W-1:0]   inst_wdata,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [1:0]          data_size,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [1:0]          mem_size,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                proto_err
);

  req_id_e winner;
  req_id_e lock_id_r;
  logic    lock_r;
  logic    proto_err_r;
  logic    win_req;
  logic    accept;
  logic    retire;
  logic    fifo_head;
  logic    fifo_full;
  logic    fifo_empty;

  // Grant, request mux and same-cycle handshake routing
  always_comb begin
    winner    = REQ_INST;
    win_req   = 1'b0;
    mem_wr    = 1'b0;
    mem_size  = 2'd0;
    mem_wstrb = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (lock_r) begin
      winner = lock_id_r;
    end else if (data_req) begin
      winner = REQ_DATA;
    end else begin
      winner = REQ_INST;
    end
    if (winner == REQ_DATA) begin
      win_req   = data_req;
      mem_wr    = data_wr;
      mem_size  = data_size;
      mem_wstrb = data_wstrb;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end else begin
      win_req   = inst_req;
      mem_wr    = inst_wr;
      mem_size  = inst_size;
      mem_wstrb = inst_wstrb;
      mem_addr  = inst_addr;
      mem_wdata = inst_wdata;
    end
    // A pop this cycle does not free the slot until the next cycle
    mem_req      = resetn & win_req & ~fifo_full;
    accept       = mem_req & mem_addr_ok;
    inst_addr_ok = accept & (winner == REQ_INST);
    data_addr_ok = accept & (winner == REQ_DATA);
    retire       = resetn & mem_data_ok & ~fifo_empty;
    inst_data_ok = retire & (fifo_head == REQ_INST);
    data_data_ok = retire & (fifo_head == REQ_DATA);
  end

  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;
  assign proto_err  = proto_err_r;

  // Address-phase lock and sticky protocol-error flag
  always_ff @(posedge clk) begin
    if (!resetn) begin
      lock_r      <= 1'b0;
      lock_id_r   <= REQ_INST;
      proto_err_r <= 1'b0;
    end else begin
      if (mem_req && !mem_addr_ok) begin
        lock_r    <= 1'b1;
        lock_id_r <= winner;
      end else if (accept) begin
        lock_r    <= 1'b0;
      end else begin
        lock_r    <= lock_r;
      end
      if (mem_data_ok && fifo_empty) begin
        proto_err_r <= 1'b1;
      end else begin
        proto_err_r <= proto_err_r;
      end
    end
  end

  sram_bus_arbiter_id_fifo #(
    .DEPTH(MAX_OUT)
  ) u_id_fifo (
    .clk   (clk),
    .resetn(resetn),
    .push  (accept),
    .pop   (retire),
    .din   (winner),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Randomized and directed bench for sram_bus_arbiter against a queue-based reference model.
module tb_sram_bus_arbiter;

  localparam int MAX_OUT = 2;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic clk = 1'b0;
  logic resetn;
  logic inst_req, inst_wr, inst_addr_ok, inst_data_ok;
  logic [1:0] inst_size;
  logic [3:0] inst_wstrb;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0] data_size;
  logic [3:0] data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic mem_req, mem_wr, mem_addr_ok, mem_data_ok, proto_err;
  logic [1:0] mem_size;
  logic [3:0] mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  sram_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .proto_err(proto_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: issue order of IDs, downstream's view, per-requester address order
  bit          exp_q[$];
  logic [31:0] mem_q[$];
  logic [31:0] iq[$];
  logic [31:0] dq[$];
  bit          lk, lk_id, perr;
  bit          acc_i, acc_d, last_mem_req;
  logic [31:0] last_irdata, last_drdata;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return a ^ 32'h1E80_0413;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    t.wr    = 1'($urandom_range(1));
    t.size  = 2'($urandom_range(2));
    t.wstrb = 4'($urandom);
    t.addr  = $urandom;
    t.wdata = $urandom;
    return t;
  endfunction

  task automatic step();
    bit want_id, want_req, full, acc, ret, head;
    @(negedge clk);
    check_eq("proto_err", proto_err, perr);
    acc_i = 1'b0;
    acc_d = 1'b0;
    if (!resetn) begin
      check_eq("rst_quiet", {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 5'b0);
      if (mem_data_ok && mem_q.size() > 0) void'(mem_q.pop_front());
      exp_q.delete(); iq.delete(); dq.delete();
      lk = 1'b0; perr = 1'b0; last_mem_req = 1'b0;
    end else begin
      full     = (exp_q.size() >= MAX_OUT);
      want_id  = lk ? lk_id : data_req;
      want_req = (want_id ? data_req : inst_req) && !full;
      last_mem_req = mem_req;
      check_eq("mem_req", mem_req, want_req);
      if (want_req) begin
        check_eq("mem_addr", mem_addr, want_id ? data_addr : inst_addr);
        check_eq("mem_ctl", {mem_wr, mem_size, mem_wstrb},
                 want_id ? {data_wr, data_size, data_wstrb} : {inst_wr, inst_size, inst_wstrb});
        check_eq("mem_wdata", mem_wdata, want_id ? data_wdata : inst_wdata);
      end
      acc  = want_req && mem_addr_ok;
      ret  = mem_data_ok && exp_q.size() > 0;
      head = ret ? exp_q[0] : 1'b0;
      check_eq("inst_addr_ok", inst_addr_ok, acc && !want_id);
      check_eq("data_addr_ok", data_addr_ok, acc && want_id);
      check_eq("inst_data_ok", inst_data_ok, ret && !head);
      check_eq("data_data_ok", data_data_ok, ret && head);
      if (ret) begin
        if (!head) begin
          check_eq("inst_rdata", inst_rdata, rd_fn(iq[0]));
          last_irdata = inst_rdata;
          void'(iq.pop_front());
        end else begin
          check_eq("data_rdata", data_rdata, rd_fn(dq[0]));
          last_drdata = data_rdata;
          void'(dq.pop_front());
        end
        void'(exp_q.pop_front());
      end
      if (mem_data_ok && mem_q.size() > 0) void'(mem_q.pop_front());
      if (mem_data_ok && !ret) perr = 1'b1;
      if (acc) begin
        exp_q.push_back(want_id);
        mem_q.push_back(want_id ? data_addr : inst_addr);
        if (want_id) begin dq.push_back(data_addr); acc_d = 1'b1; end
        else begin iq.push_back(inst_addr); acc_i = 1'b1; end
      end
      if (want_req && !mem_addr_ok) begin
        lk = 1'b1; lk_id = want_id;
      end else if (acc) begin
        lk = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_inst(input logic req, input txn_t t);
    inst_req = req; inst_wr = t.wr; inst_size = t.size; inst_wstrb = t.wstrb;
    inst_addr = t.addr; inst_wdata = t.wdata;
  endtask

  task automatic set_data(input logic req, input txn_t t);
    data_req = req; data_wr = t.wr; data_size = t.size; data_wstrb = t.wstrb;
    data_addr = t.addr; data_wdata = t.wdata;
  endtask

  task automatic ret_one();
    mem_data_ok = (mem_q.size() > 0) ? 1'b1 : 1'b0;
    mem_rdata   = (mem_q.size() > 0) ? rd_fn(mem_q[0]) : $urandom;
  endtask

  // Let pending requests be accepted and every outstanding response return
  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (inst_req && acc_i) inst_req = 1'b0;
      if (data_req && acc_d) data_req = 1'b0;
      if (!inst_req && !data_req && mem_q.size() == 0) break;
      mem_addr_ok = 1'b1;
      ret_one();
      step();
    end
    inst_req = 1'b0; data_req = 1'b0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    check_eq("drained", 64'(mem_q.size() + exp_q.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t t;
    txn_t z;
    z = '0;
    resetn = 1'b0;
    set_inst(1'b0, z); set_data(1'b0, z);
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
    lk = 1'b0; lk_id = 1'b0; perr = 1'b0;
    last_irdata = '0; last_drdata = '0;
    @(posedge clk); #1;
    // Requests during reset must stay invisible
    set_inst(1'b1, rand_txn()); mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    step();
    step();
    set_inst(1'b0, z); mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    resetn = 1'b1;
    step();

    // Single instruction read, response two cycles after acceptance
    t = '0; t.size = 2'd2; t.addr = 32'h1C00_0000;
    set_inst(1'b1, t); mem_addr_ok = 1'b1;
    step();
    check_eq("t1_accept", acc_i, 1'b1);
    set_inst(1'b0, z); mem_addr_ok = 1'b0;
    step();
    ret_one();
    step();
    mem_data_ok = 1'b0;
    check_eq("t1_rdata", last_irdata, 32'h0280_0413);

    // Simultaneous requests: data wins, inst follows, returns in issue order
    t = '0; t.wr = 1'b1; t.size = 2'd2; t.wstrb = 4'hF; t.addr = 32'h1C00_8000; t.wdata = 32'hCAFE_0001;
    set_data(1'b1, t);
    t = '0; t.size = 2'd2; t.addr = 32'h1C00_0100;
    set_inst(1'b1, t); mem_addr_ok = 1'b1;
    step();
    check_eq("t2_data_first", {acc_d, acc_i}, 2'b10);
    set_data(1'b0, z);
    step();
    check_eq("t2_inst_next", {acc_d, acc_i}, 2'b01);
    set_inst(1'b0, z); mem_addr_ok = 1'b0;
    ret_one(); step();
    check_eq("t2_data_ret", last_drdata, rd_fn(32'h1C00_8000));
    ret_one(); step();
    mem_data_ok = 1'b0;
    check_eq("t2_inst_ret", last_irdata, rd_fn(32'h1C00_0100));

    // Stalled inst address phase must not be stolen by a later data request
    t = rand_txn(); set_inst(1'b1, t); mem_addr_ok = 1'b0;
    step();
    set_data(1'b1, rand_txn());
    step();
    step();
    check_eq("t3_locked_addr", mem_addr, t.addr);
    mem_addr_ok = 1'b1;
    step();
    check_eq("t3_inst_acc", {acc_d, acc_i}, 2'b01);
    set_inst(1'b0, z);
    step();
    check_eq("t3_data_acc", {acc_d, acc_i}, 2'b10);
    set_data(1'b0, z);
    drain();

    // Fill to MAX_OUT and observe back-pressure release one cycle after a pop
    mem_addr_ok = 1'b1;
    t = rand_txn(); t.wr = 1'b0; set_inst(1'b1, t);
    step();
    t = rand_txn(); t.wr = 1'b0; set_inst(1'b1, t);
    step();
    t = rand_txn(); t.wr = 1'b0; set_inst(1'b1, t);
    step();
    check_eq("t4_full_block", last_mem_req, 1'b0);
    ret_one(); step();
    check_eq("t4_pop_cycle", last_mem_req, 1'b0);
    mem_data_ok = 1'b0;
    step();
    check_eq("t4_unblocked", last_mem_req, 1'b1);
    drain();

    // Randomized mixed traffic
    for (int c = 0; c < 600; c++) begin
      if (inst_req && acc_i) inst_req = 1'b0;
      if (data_req && acc_d) data_req = 1'b0;
      if (!inst_req && $urandom_range(2) == 0) set_inst(1'b1, rand_txn());
      if (!data_req && $urandom_range(2) == 0) set_data(1'b1, rand_txn());
      mem_addr_ok = ((c / 50) % 2 == 0) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
      if ($urandom_range(1) == 1) ret_one();
      else begin mem_data_ok = 1'b0; mem_rdata = $urandom; end
      step();
    end
    drain();

    // Response with nothing outstanding sets a sticky error
    mem_data_ok = 1'b1; mem_rdata = 32'h1234_5678;
    step();
    mem_data_ok = 1'b0;
    step();
    check_eq("t6_perr_set", proto_err, 1'b1);
    step();
    check_eq("t6_perr_held", proto_err, 1'b1);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    step();
    check_eq("t6_perr_clr", proto_err, 1'b0);

    // Reset mid-transaction discards the ID; the late response is an error
    set_inst(1'b1, rand_txn()); mem_addr_ok = 1'b1;
    step();
    set_inst(1'b0, z); mem_addr_ok = 1'b0;
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    ret_one(); step();
    mem_data_ok = 1'b0;
    step();
    check_eq("t6_late_resp", proto_err, 1'b1);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    set_inst(1'b1, rand_txn()); mem_addr_ok = 1'b1;
    step();
    check_eq("t6_post_rst_acc", acc_i, 1'b1);
    drain();
    check_eq("t6_final_perr", proto_err, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
